// File: rtl/conv1_pkg.sv
// Shared constants and types for the first convolution layer's input stage.
package conv1_pkg;

  localparam int WIDTH           = 28;
  localparam int HEIGHT          = 28;
  localparam int DATA_BITS       = 8;
  localparam int FILTER_SIZE     = 5;

  // Enough history to reach from the newest pixel back to the top-left tap.
  localparam int BUF_LEN         = (FILTER_SIZE-1)*WIDTH + FILTER_SIZE;
  localparam int NUM_TAPS        = FILTER_SIZE*FILTER_SIZE;
  localparam int VALID_PER_FRAME = (WIDTH-FILTER_SIZE+1)*(HEIGHT-FILTER_SIZE+1);

  localparam int COL_W           = $clog2(WIDTH);
  localparam int ROW_W           = $clog2(HEIGHT);

  typedef logic [DATA_BITS-1:0] pixel_t;

endpackage

// File: rtl/conv1_pos_counter.sv
// Raster position of the next pixel to be accepted, plus window/frame flags.
module conv1_pos_counter
  import conv1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  output logic in_window,
  output logic last_pixel
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT-1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(FILTER_SIZE-1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(FILTER_SIZE-1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Advance col/row on each accepted pixel, wrapping at line and frame ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A window is complete only when the pixel being accepted is its bottom-right
  // corner and the whole 5x5 footprint lies inside the current frame.
  assign in_window  = (row >= ROW_WIN) && (col >= COL_WIN);
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/conv1_buf.sv
// Line buffer + 5x5 window generator for the conv1 sum stage.
module conv1_buf
  import conv1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out_0,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic [DATA_BITS-1:0] data_out_4,
  output logic [DATA_BITS-1:0] data_out_5,
  output logic [DATA_BITS-1:0] data_out_6,
  output logic [DATA_BITS-1:0] data_out_7,
  output logic [DATA_BITS-1:0] data_out_8,
  output logic [DATA_BITS-1:0] data_out_9,
  output logic [DATA_BITS-1:0] data_out_10,
  output logic [DATA_BITS-1:0] data_out_11,
  output logic [DATA_BITS-1:0] data_out_12,
  output logic [DATA_BITS-1:0] data_out_13,
  output logic [DATA_BITS-1:0] data_out_14,
  output logic [DATA_BITS-1:0] data_out_15,
  output logic [DATA_BITS-1:0] data_out_16,
  output logic [DATA_BITS-1:0] data_out_17,
  output logic [DATA_BITS-1:0] data_out_18,
  output logic [DATA_BITS-1:0] data_out_19,
  output logic [DATA_BITS-1:0] data_out_20,
  output logic [DATA_BITS-1:0] data_out_21,
  output logic [DATA_BITS-1:0] data_out_22,
  output logic [DATA_BITS-1:0] data_out_23,
  output logic [DATA_BITS-1:0] data_out_24,
  output logic                 valid_out_buf,
  output logic                 frame_done
);

  pixel_t [BUF_LEN-1:0]  sr;
  pixel_t [NUM_TAPS-1:0] taps;
  logic                  in_window;
  logic                  last_pixel;

  conv1_pos_counter u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (valid_in),
    .in_window (in_window),
    .last_pixel(last_pixel)
  );

  // Pixel history: newest at sr[0]; holds on stall, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n)        sr <= '0;
    else if (valid_in) sr <= {sr[BUF_LEN-2:0], data_in};
  end

  // Flags registered so they line up with the taps updated by the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      valid_out_buf <= valid_in & in_window;
      frame_done    <= valid_in & last_pixel;
    end
  end

  // Tap r,c sits (4-r) lines and (4-c) pixels behind the newest pixel.
  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
      assign taps[r*FILTER_SIZE+c] = sr[(FILTER_SIZE-1-r)*WIDTH + (FILTER_SIZE-1-c)];
    end
  end

  assign data_out_0  = taps[0];
  assign data_out_1  = taps[1];
  assign data_out_2  = taps[2];
  assign data_out_3  = taps[3];
  assign data_out_4  = taps[4];
  assign data_out_5  = taps[5];
  assign data_out_6  = taps[6];
  assign data_out_7  = taps[7];
  assign data_out_8  = taps[8];
  assign data_out_9  = taps[9];
  assign data_out_10 = taps[10];
  assign data_out_11 = taps[11];
  assign data_out_12 = taps[12];
  assign data_out_13 = taps[13];
  assign data_out_14 = taps[14];
  assign data_out_15 = taps[15];
  assign data_out_16 = taps[16];
  assign data_out_17 = taps[17];
  assign data_out_18 = taps[18];
  assign data_out_19 = taps[19];
  assign data_out_20 = taps[20];
  assign data_out_21 = taps[21];
  assign data_out_22 = taps[22];
  assign data_out_23 = taps[23];
  assign data_out_24 = taps[24];

endmodule

// File: tb/tb_conv1_buf.sv
// Scoreboard bench for conv1_buf: windows are derived from a 2-D image model.
module tb_conv1_buf;
  import conv1_pkg::*;

  typedef logic [NUM_TAPS-1:0][DATA_BITS-1:0] win_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [7:0] data_out_5, data_out_6, data_out_7, data_out_8, data_out_9;
  logic [7:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14;
  logic [7:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19;
  logic [7:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24;
  logic       valid_out_buf, frame_done;
  win_t       dout;

  always #5 clk = ~clk;

  conv1_buf dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .data_out_0(data_out_0),   .data_out_1(data_out_1),   .data_out_2(data_out_2),
    .data_out_3(data_out_3),   .data_out_4(data_out_4),   .data_out_5(data_out_5),
    .data_out_6(data_out_6),   .data_out_7(data_out_7),   .data_out_8(data_out_8),
    .data_out_9(data_out_9),   .data_out_10(data_out_10), .data_out_11(data_out_11),
    .data_out_12(data_out_12), .data_out_13(data_out_13), .data_out_14(data_out_14),
    .data_out_15(data_out_15), .data_out_16(data_out_16), .data_out_17(data_out_17),
    .data_out_18(data_out_18), .data_out_19(data_out_19), .data_out_20(data_out_20),
    .data_out_21(data_out_21), .data_out_22(data_out_22), .data_out_23(data_out_23),
    .data_out_24(data_out_24),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
  );

  assign dout = {data_out_24, data_out_23, data_out_22, data_out_21, data_out_20,
                 data_out_19, data_out_18, data_out_17, data_out_16, data_out_15,
                 data_out_14, data_out_13, data_out_12, data_out_11, data_out_10,
                 data_out_9,  data_out_8,  data_out_7,  data_out_6,  data_out_5,
                 data_out_4,  data_out_3,  data_out_2,  data_out_1,  data_out_0};

  int         n_tests = 0;
  int         n_fail  = 0;
  win_t       exp_q[$];
  logic [7:0] img [HEIGHT][WIDTH];
  int         mr = 0, mc = 0;
  int         nvalid = 0, nfd = 0, n_acc = 0, mode = 0;
  win_t       last_w = '0;
  logic       hold_ok = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ramp(input int idx);
    return 8'(idx % 256);
  endfunction

  task automatic begin_frame(input int m);
    mode = m; nvalid = 0; nfd = 0; n_acc = 0;
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_valid_count"}, nvalid, VALID_PER_FRAME);
    check({tag, "_frame_done_count"}, nfd, 1);
  endtask

  // Spot checks on specific windows with hand-derived ramp values.
  task automatic spot();
    if (mode == 1 && nvalid == 1) begin
      check("first_win_index", n_acc, BUF_LEN);
      check("first_d0",  data_out_0,  0);
      check("first_d4",  data_out_4,  4);
      check("first_d5",  data_out_5,  28);
      check("first_d20", data_out_20, 112);
      check("first_d24", data_out_24, 116);
    end
    if (mode == 1 && nvalid == 25) begin
      check("rowwrap_d24", data_out_24, 144);
      check("rowwrap_d0",  data_out_0,  28);
    end
    if (mode == 1 && nvalid == VALID_PER_FRAME) begin
      check("last_d24", data_out_24, 15);
      check("last_fd",  frame_done,  1);
    end
    if (mode == 2 && nvalid == 1) begin
      check("f2_first_d0", data_out_0, 8'h55);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample #1 later.
  task automatic step(input logic v, input logic [7:0] d);
    logic ev, efd;
    win_t w;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    ev = 1'b0; efd = 1'b0; w = '0;
    if (!rst_n) begin
      mr = 0; mc = 0; exp_q.delete(); hold_ok = 1'b0;
    end else if (v) begin
      img[mr][mc] = d;
      n_acc++;
      if (mr >= FILTER_SIZE-1 && mc >= FILTER_SIZE-1) begin
        for (int i = 0; i < FILTER_SIZE; i++)
          for (int j = 0; j < FILTER_SIZE; j++)
            w[i*FILTER_SIZE+j] = img[mr-FILTER_SIZE+1+i][mc-FILTER_SIZE+1+j];
        exp_q.push_back(w);
        ev = 1'b1;
      end
      efd = (mr == HEIGHT-1 && mc == WIDTH-1);
      if (mc == WIDTH-1) begin
        mc = 0;
        mr = (mr == HEIGHT-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
      hold_ok = 1'b0;
    end
    #1;
    check("valid_out_buf", valid_out_buf, ev);
    check("frame_done", frame_done, efd);
    if (frame_done) nfd++;
    if (valid_out_buf) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL window: valid with empty scoreboard");
      end else begin
        w = exp_q.pop_front();
        check("window", dout, w);
        last_w  = w;
        hold_ok = 1'b1;
        spot();
      end
    end else if (rst_n && !v && hold_ok) begin
      check("stall_hold", dout, last_w);
    end
    @(negedge clk);
  endtask

  task automatic ramp_frame(input logic [7:0] x);
    for (int i = 0; i < WIDTH*HEIGHT; i++) step(1'b1, ramp(i) ^ x);
  endtask

  initial begin
    // Reset with valid_in high and all-ones data must be ignored.
    rst_n = 1'b0;
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    check("rst_taps", dout, '0);
    rst_n = 1'b1;

    // Continuous ramp frame with boundary spot checks.
    begin_frame(1);
    ramp_frame(8'h00);
    end_frame("ramp");

    // Same frame with random input gaps.
    begin_frame(0);
    for (int i = 0; i < WIDTH*HEIGHT; ) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, ramp(i));
        i++;
      end else begin
        step(1'b0, 8'($urandom_range(0, 255)));
      end
    end
    end_frame("gaps");

    // Two back-to-back frames, the second XOR 0x55.
    begin_frame(0);
    ramp_frame(8'h00);
    end_frame("b2b_f1");
    begin_frame(2);
    ramp_frame(8'h55);
    end_frame("b2b_f2");

    // Abort mid-frame with reset, then a full fresh frame.
    begin_frame(0);
    for (int i = 0; i < 300; i++) step(1'b1, ramp(i) ^ 8'hA5);
    rst_n = 1'b0;
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    check("midrst_taps", dout, '0);
    rst_n = 1'b1;
    begin_frame(1);
    ramp_frame(8'h00);
    end_frame("post_rst");

    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
